// File: rtl/hqc_fw_pkg.sv
// Shared HQC fixed-weight sampler constants: per-parameter-set N, M, W, THRESH,
// scheduler state encoding and the log2ceil helper.
package hqc_fw_pkg;

   localparam int RAND_W = 24;

   localparam int HQC128_N      = 17669;
   localparam int HQC128_M      = 15;
   localparam int HQC128_W      = 66;
   localparam int HQC128_THRESH = 16767881;

   localparam int HQC192_N      = 35851;
   localparam int HQC192_M      = 16;
   localparam int HQC192_W      = 100;
   localparam int HQC192_THRESH = 16742417;

   localparam int HQC256_N      = 57637;
   localparam int HQC256_M      = 16;
   localparam int HQC256_W      = 131;
   localparam int HQC256_THRESH = 16772367;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_e;

   function automatic int log2ceil(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/hqc_barrett_red.sv
// Two-cycle Barrett reducer: r = a mod N for 24-bit a. With k = 24 the quotient
// estimate is at most one short, so a single conditional subtract finishes it.
module hqc_barrett_red
   import hqc_fw_pkg::*;
#(
   parameter int N = HQC128_N,
   parameter int M = HQC128_M
)(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [RAND_W-1:0] a_i,
   output logic [M-1:0]      r_o
);
   localparam int                MU   = (1 << RAND_W) / N;
   localparam logic [RAND_W-1:0] N_V  = RAND_W'(N);
   localparam logic [RAND_W-1:0] MU_V = RAND_W'(MU);

   logic [2*RAND_W-1:0] prod_s;
   logic [RAND_W-1:0]   a_r, q_r, qn_s, rem_s, red_s;
   logic [M-1:0]        r_r;

   assign prod_s = {{RAND_W{1'b0}}, a_i} * {{RAND_W{1'b0}}, MU_V};
   assign qn_s   = q_r * N_V;
   assign rem_s  = a_r - qn_s;
   assign red_s  = (rem_s >= N_V) ? (rem_s - N_V) : rem_s;
   assign r_o    = r_r;

   // Stage 1 registers operand and quotient estimate; stage 2 registers the residue.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_r <= {RAND_W{1'b0}};
         q_r <= {RAND_W{1'b0}};
         r_r <= {M{1'b0}};
      end else begin
         a_r <= a_i;
         q_r <= RAND_W'(prod_s >> RAND_W);
         r_r <= M'(red_s);
      end
   end

endmodule

// File: rtl/hqc_fw_red_sched.sv
// Rejection-samples PRNG words, reduces survivors mod N and streams exactly W
// positions through a credit-protected output FIFO.
module hqc_fw_red_sched
   import hqc_fw_pkg::*;
#(
   parameter string parameter_set = "hqc128",
   parameter int    N      = (parameter_set == "hqc256") ? HQC256_N :
                             (parameter_set == "hqc192") ? HQC192_N : HQC128_N,
   parameter int    M      = (parameter_set == "hqc256") ? HQC256_M :
                             (parameter_set == "hqc192") ? HQC192_M : HQC128_M,
   parameter int    W      = (parameter_set == "hqc256") ? HQC256_W :
                             (parameter_set == "hqc192") ? HQC192_W : HQC128_W,
   parameter int    THRESH = (parameter_set == "hqc256") ? HQC256_THRESH :
                             (parameter_set == "hqc192") ? HQC192_THRESH : HQC128_THRESH,
   parameter int    FIFO_DEPTH = 4
)(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic [RAND_W-1:0] rand_data_i,
   input  logic              rand_valid_i,
   output logic              rand_ready_o,
   output logic [M-1:0]      pos_o,
   output logic              pos_valid_o,
   input  logic              pos_ready_i
);
   localparam int CW = log2ceil(W + 1);
   localparam int FW = log2ceil(FIFO_DEPTH + 1);
   localparam int PW = log2ceil(FIFO_DEPTH);
   localparam logic [RAND_W-1:0] THRESH_V = RAND_W'(THRESH);

   sched_state_e      state_r, state_s;
   logic [CW-1:0]     issued_r, popped_r;
   logic [1:0]        valid_sr_r;
   logic [M-1:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [FW-1:0]     fifo_cnt_r, inflight_s;
   logic [FW:0]       occupancy_s;
   logic              fire_s, issue_s, push_s, pop_s, start_s;
   logic [RAND_W-1:0] red_in_s;
   logic [M-1:0]      red_out_s;

   // Credit: every word in the reducer already owns a FIFO slot.
   assign inflight_s   = FW'(valid_sr_r[0]) + FW'(valid_sr_r[1]);
   assign occupancy_s  = {1'b0, fifo_cnt_r} + {1'b0, inflight_s};
   assign rand_ready_o = (state_r == ST_RUN) && (occupancy_s < (FW + 1)'(FIFO_DEPTH));
   assign fire_s       = rand_valid_i && rand_ready_o;
   assign issue_s      = fire_s && (rand_data_i < THRESH_V);
   assign red_in_s     = issue_s ? rand_data_i : {RAND_W{1'b0}};
   assign push_s       = valid_sr_r[1];
   assign pos_valid_o  = (fifo_cnt_r != {FW{1'b0}});
   assign pop_s        = pos_valid_o && pos_ready_i;
   assign pos_o        = pos_valid_o ? fifo_mem_r[rd_ptr_r] : {M{1'b0}};
   assign start_s      = (state_r == ST_IDLE) && start_i;
   assign busy_o       = (state_r != ST_IDLE);
   assign done_o       = (state_r == ST_DRAIN) && pop_s && (popped_r == CW'(W - 1));

   hqc_barrett_red #(
      .N (N),
      .M (M)
   ) u_red (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .a_i    (red_in_s),
      .r_o    (red_out_s)
   );

   // Next-state logic for the run sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  if (start_i) state_s = ST_RUN; else state_s = ST_IDLE;
         ST_RUN:   if (issue_s && (issued_r == CW'(W - 1))) state_s = ST_DRAIN;
                   else state_s = ST_RUN;
         ST_DRAIN: if (done_o) state_s = ST_IDLE; else state_s = ST_DRAIN;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State, run counters and reducer valid pipeline.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ST_IDLE;
         issued_r   <= {CW{1'b0}};
         popped_r   <= {CW{1'b0}};
         valid_sr_r <= 2'b00;
      end else begin
         state_r    <= state_s;
         valid_sr_r <= {valid_sr_r[0], issue_s};
         if (start_s) begin
            issued_r <= {CW{1'b0}};
            popped_r <= {CW{1'b0}};
         end else begin
            if (issue_s) issued_r <= issued_r + CW'(1);
            if (pop_s)   popped_r <= popped_r + CW'(1);
         end
      end
   end

   // Output FIFO; the credit rule keeps pushes off a full buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         fifo_cnt_r <= {FW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= {M{1'b0}};
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= red_out_s;
            wr_ptr_r <= (wr_ptr_r == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
         end
         fifo_cnt_r <= fifo_cnt_r + FW'(push_s) - FW'(pop_s);
      end
   end

endmodule

// File: tb/tb_hqc_fw_red_sched.sv
// Directed bench for hqc_fw_red_sched: hqc128 instance for most scenarios, hqc256 for one.
module tb_hqc_fw_red_sched;
   logic        clk, rst_ni;
   logic        start, rand_valid, pos_ready;
   logic [23:0] rand_data;
   logic        busy, done, rand_ready, pos_valid;
   logic [14:0] pos;
   logic        start2, rv2, pr2, busy2, done2, ready2, pv2;
   logic [23:0] rd2;
   logic [15:0] pos2;
   int          checks, fails, cyc;

   hqc_fw_red_sched dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .busy_o(busy), .done_o(done),
      .rand_data_i(rand_data), .rand_valid_i(rand_valid), .rand_ready_o(rand_ready),
      .pos_o(pos), .pos_valid_o(pos_valid), .pos_ready_i(pos_ready));

   hqc_fw_red_sched #(.parameter_set("hqc256")) dut256 (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start2), .busy_o(busy2), .done_o(done2),
      .rand_data_i(rd2), .rand_valid_i(rv2), .rand_ready_o(ready2),
      .pos_o(pos2), .pos_valid_o(pv2), .pos_ready_i(pr2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle(input logic rv, input logic [23:0] rd, input logic pr, input logic st,
                        output logic fired, output logic popped, output logic [14:0] p,
                        output logic dn);
      @(negedge clk);
      rand_valid = rv; rand_data = rd; pos_ready = pr; start = st;
      #1;
      cyc    = cyc + 1;
      fired  = rv & rand_ready;
      popped = pos_valid & pr;
      p      = pos;
      dn     = done;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0; start = 1'b0; rand_valid = 1'b0; pos_ready = 1'b0; rand_data = 24'd0;
      start2 = 1'b0; rv2 = 1'b0; pr2 = 1'b0; rd2 = 24'd0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; start = 1'b0; rand_valid = 1'b0; pos_ready = 1'b0; rand_data = 24'd0;
      start2 = 1'b0; rv2 = 1'b0; pr2 = 1'b0; rd2 = 24'd0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (rand_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", rand_ready); end
      checks++; if (pos_valid !== 1'b0) begin fails++; $display("FAIL reset_pos_valid: got %b want 0", pos_valid); end
      checks++; if (pos !== 15'd0) begin fails++; $display("FAIL reset_pos: got %0d want 0", pos); end
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_basic();
      logic f, pp, d;
      logic [14:0] p;
      logic [23:0] words [4];
      logic [14:0] expv [4];
      int idx, npop, fire_cyc, pop_cyc;
      words = '{24'd0, 24'd17669, 24'd16767880, 24'd12345678};
      expv  = '{15'd0, 15'd0, 15'd17668, 15'd12716};
      do_reset();
      cycle(1'b0, 24'd0, 1'b1, 1'b1, f, pp, p, d);
      cycle(1'b0, 24'd0, 1'b1, 1'b0, f, pp, p, d);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy: got %b want 1", busy); end
      checks++; if (rand_ready !== 1'b1) begin fails++; $display("FAIL start_ready: got %b want 1", rand_ready); end
      idx = 0; npop = 0; fire_cyc = -1; pop_cyc = -1;
      for (int c = 0; c < 16; c++) begin
         cycle(idx < 4, (idx < 4) ? words[idx] : 24'd0, 1'b1, 1'b0, f, pp, p, d);
         if (f) begin
            if (idx == 0) fire_cyc = cyc;
            idx++;
         end
         if (pp) begin
            if (npop == 0) pop_cyc = cyc;
            checks++;
            if (npop >= 4 || p !== expv[npop]) begin
               fails++; $display("FAIL basic_pos[%0d]: got %0d", npop, p);
            end
            npop++;
         end
      end
      checks++; if (npop != 4) begin fails++; $display("FAIL basic_count: got %0d want 4", npop); end
      checks++;
      if (pop_cyc != fire_cyc + 3) begin
         fails++; $display("FAIL basic_latency: got %0d want 3", pop_cyc - fire_cyc);
      end
   endtask

   task automatic test_reject();
      logic f, pp, d;
      logic [14:0] p;
      logic [23:0] words [3];
      int idx, npop, fire_cyc, pop_cyc;
      words = '{24'd16767881, 24'd16777215, 24'd5};
      do_reset();
      cycle(1'b0, 24'd0, 1'b1, 1'b1, f, pp, p, d);
      idx = 0; npop = 0; fire_cyc = -1; pop_cyc = -1;
      for (int c = 0; c < 12; c++) begin
         cycle(idx < 3, (idx < 3) ? words[idx] : 24'd0, 1'b1, 1'b0, f, pp, p, d);
         if (c < 2) begin
            checks++; if (f !== 1'b1) begin fails++; $display("FAIL reject_consumed[%0d]: got %b want 1", c, f); end
         end
         if (f) begin
            if (idx == 2) fire_cyc = cyc;
            idx++;
         end
         if (pp) begin
            if (npop == 0) pop_cyc = cyc;
            checks++; if (p !== 15'd5) begin fails++; $display("FAIL reject_pos: got %0d want 5", p); end
            npop++;
         end
      end
      checks++; if (npop != 1) begin fails++; $display("FAIL reject_count: got %0d want 1", npop); end
      checks++;
      if (pop_cyc != fire_cyc + 3) begin
         fails++; $display("FAIL reject_latency: got %0d want 3", pop_cyc - fire_cyc);
      end
   endtask

   task automatic test_backpressure();
      logic f, pp, d;
      logic [14:0] p;
      int nf, nf_after, npop;
      do_reset();
      cycle(1'b0, 24'd0, 1'b0, 1'b1, f, pp, p, d);
      nf = 0;
      for (int c = 0; c < 10; c++) begin
         cycle(1'b1, 24'(100 + nf), 1'b0, 1'b0, f, pp, p, d);
         if (f) nf++;
      end
      checks++; if (nf != 4) begin fails++; $display("FAIL bp_buffered: got %0d want 4", nf); end
      checks++; if (rand_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low: got %b want 0", rand_ready); end
      checks++; if (pos_valid !== 1'b1 || pos !== 15'd100) begin
         fails++; $display("FAIL bp_head: got valid %b pos %0d want 1/100", pos_valid, pos);
      end
      nf_after = 0; npop = 0;
      for (int c = 0; c < 12; c++) begin
         cycle(1'b1, 24'(100 + nf), 1'b1, 1'b0, f, pp, p, d);
         if (f) begin nf++; nf_after++; end
         if (pp) begin
            checks++;
            if (p !== 15'(100 + npop)) begin
               fails++; $display("FAIL bp_order[%0d]: got %0d want %0d", npop, p, 100 + npop);
            end
            npop++;
         end
      end
      checks++; if (npop != 12) begin fails++; $display("FAIL bp_pops: got %0d want 12", npop); end
      checks++; if (nf_after != 11) begin fails++; $display("FAIL bp_resume: got %0d want 11", nf_after); end
   endtask

   task automatic test_full_run();
      logic f, pp, d, pr, st, prev_last, restarted;
      logic [14:0] p;
      int words [67];
      int nf, np, nd, post;
      for (int i = 0; i < 67; i++) words[i] = int'($urandom_range(0, 16767880));
      do_reset();
      cycle(1'b0, 24'd0, 1'b0, 1'b1, f, pp, p, d);
      nf = 0; np = 0; nd = 0; post = 0; prev_last = 1'b0; restarted = 1'b0;
      for (int c = 0; c < 800 && post < 8; c++) begin
         pr = 1'($urandom_range(0, 1));
         st = (nf == 20) && !restarted;
         if (st) restarted = 1'b1;
         cycle(nf < 67, (nf < 67) ? 24'(words[nf]) : 24'd0, pr, st, f, pp, p, d);
         if (prev_last) begin
            checks++; if (rand_ready !== 1'b0) begin fails++; $display("FAIL full_ready_after_last: got %b want 0", rand_ready); end
         end
         if (f) nf++;
         prev_last = f && (nf == 66);
         if (pp) begin
            if (np < 66) begin
               checks++;
               if (p !== 15'(words[np] % 17669)) begin
                  fails++; $display("FAIL full_pos[%0d]: got %0d want %0d", np, p, words[np] % 17669);
               end
            end
            np++;
         end
         if (d) begin
            nd++;
            checks++; if (!(pp && np == 66)) begin fails++; $display("FAIL full_done_align: got pop %b count %0d want 1/66", pp, np); end
         end
         if (nd > 0) post++;
      end
      checks++; if (nf != 66) begin fails++; $display("FAIL full_consumed: got %0d want 66", nf); end
      checks++; if (np != 66) begin fails++; $display("FAIL full_pops: got %0d want 66", np); end
      checks++; if (nd != 1) begin fails++; $display("FAIL full_done_pulses: got %0d want 1", nd); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_reset_midrun();
      logic f, pp, d;
      logic [14:0] p;
      logic [14:0] expv [2];
      int nf, npop;
      expv = '{15'd7, 15'd1};
      do_reset();
      cycle(1'b0, 24'd0, 1'b0, 1'b1, f, pp, p, d);
      nf = 0;
      for (int c = 0; c < 4; c++) begin
         cycle(1'b1, 24'(200 + c), 1'b0, 1'b0, f, pp, p, d);
         if (f) nf++;
      end
      checks++; if (nf != 4) begin fails++; $display("FAIL mid_fill: got %0d want 4", nf); end
      @(negedge clk);
      rst_ni = 1'b0; rand_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rand_ready !== 1'b0 || pos_valid !== 1'b0 || pos !== 15'd0) begin
         fails++; $display("FAIL mid_reset_outputs: got busy %b done %b ready %b valid %b pos %0d want all 0",
                           busy, done, rand_ready, pos_valid, pos);
      end
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      cycle(1'b0, 24'd0, 1'b1, 1'b1, f, pp, p, d);
      nf = 0; npop = 0;
      for (int c = 0; c < 12; c++) begin
         cycle(nf < 2, (nf == 0) ? 24'd7 : 24'd17670, 1'b1, 1'b0, f, pp, p, d);
         if (f) nf++;
         if (pp) begin
            checks++;
            if (npop >= 2 || p !== expv[npop]) begin
               fails++; $display("FAIL mid_after_pos[%0d]: got %0d", npop, p);
            end
            npop++;
         end
      end
      checks++; if (npop != 2) begin fails++; $display("FAIL mid_after_count: got %0d want 2", npop); end
   endtask

   task automatic test_hqc256();
      logic got;
      do_reset();
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; rv2 = 1'b1; rd2 = 24'd16772366; pr2 = 1'b1;
      #1;
      checks++; if (ready2 !== 1'b1) begin fails++; $display("FAIL h256_consumed: got %b want 1", ready2); end
      got = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         rv2 = 1'b0;
         start2 = (k == 1);
         #1;
         if (pv2 && !got) begin
            got = 1'b1;
            checks++; if (k != 3) begin fails++; $display("FAIL h256_latency: got %0d want 3", k); end
            checks++; if (pos2 !== 16'd57636) begin fails++; $display("FAIL h256_pos: got %0d want 57636", pos2); end
         end
      end
      checks++; if (!got) begin fails++; $display("FAIL h256_no_output: got none want 1"); end
      checks++; if (busy2 !== 1'b1) begin fails++; $display("FAIL h256_busy: got %b want 1", busy2); end
   endtask

   initial begin
      checks = 0; fails = 0; cyc = 0;
      test_reset();
      test_basic();
      test_reject();
      test_backpressure();
      test_full_run();
      test_reset_midrun();
      test_hqc256();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
